// File: rtl/leve_axir_arb_if.sv
// leve_axir_arb_if: AXI read-channel bundle (AR + R) shared by requesters and the target port
// Params: AW address width, DW data width, LW burst length width
// master modport drives AR and RREADY; slave modport drives ARREADY and R
`ifndef XLEN
`define XLEN 32
`endif
interface leve_axir_arb_if #(
  parameter int AW = `XLEN,
  parameter int DW = `XLEN,
  parameter int LW = 8
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [LW-1:0] arlen;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  modport master (output arvalid, araddr, arlen, rready, input arready, rvalid, rdata, rresp, rlast);
  modport slave  (input arvalid, araddr, arlen, rready, output arready, rvalid, rdata, rresp, rlast);
endinterface

// File: rtl/leve_axir_arb.sv
// leve_axir_arb: 2:1 AXI read arbiter, S0 fetch / S1 load onto one target, one transaction outstanding
// Ports: CLK clock; RST sync active-high reset; s0_i/s1_i requester buses (slave side);
// m_o target bus (master side). Define LEVE_ARB_RR_EN for round-robin, else S1 has fixed priority.
`ifndef XLEN
`define XLEN 32
`endif
module leve_axir_arb #(
  parameter int AW = `XLEN,
  parameter int DW = `XLEN,
  parameter int LW = 8
) (
  input  logic             CLK,
  input  logic             RST,
  leve_axir_arb_if.slave   s0_i,
  leve_axir_arb_if.slave   s1_i,
  leve_axir_arb_if.master  m_o
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic          any, win, idle, sel0, sel1;
  assign any  = s0_i.arvalid | s1_i.arvalid;
  assign idle = state_q == IDLE;
`ifdef LEVE_ARB_RR_EN
  logic rr_q, rr_d;
  // pointer names the preferred requester under contention
  assign win  = (s0_i.arvalid & s1_i.arvalid) ? rr_q : s1_i.arvalid;
  assign rr_d = (idle & any) ? ~win : rr_q;
  always_ff @(posedge CLK) rr_q <= RST ? 1'b0 : rr_d;
`else
  assign win = s1_i.arvalid;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    if (idle && any) begin
      state_d = ADDR;
      gnt_d   = win;
      addr_d  = win ? AW'(s1_i.araddr) : AW'(s0_i.araddr);
      len_d   = win ? LW'(s1_i.arlen) : LW'(s0_i.arlen);
    end else if (state_q == ADDR && m_o.arready) begin
      state_d = DATA;
    end else if (state_q == DATA && m_o.rvalid && m_o.rready && m_o.rlast) begin
      state_d = IDLE;
    end
  end
  assign s0_i.arready = idle & s0_i.arvalid & ~win;
  assign s1_i.arready = idle & s1_i.arvalid & win;
  assign m_o.arvalid  = state_q == ADDR;
  assign m_o.araddr   = addr_q;
  assign m_o.arlen    = len_q;
  // R is only routed while a transaction is in DATA; stray target beats elsewhere are ignored
  assign sel0 = (state_q == DATA) & ~gnt_q;
  assign sel1 = (state_q == DATA) & gnt_q;
  assign m_o.rready  = sel1 ? s1_i.rready : sel0 & s0_i.rready;
  assign s0_i.rvalid = sel0 & m_o.rvalid;
  assign s0_i.rdata  = sel0 ? m_o.rdata : '0;
  assign s0_i.rresp  = sel0 ? m_o.rresp : 2'b00;
  assign s0_i.rlast  = sel0 & m_o.rlast;
  assign s1_i.rvalid = sel1 & m_o.rvalid;
  assign s1_i.rdata  = sel1 ? m_o.rdata : '0;
  assign s1_i.rresp  = sel1 ? m_o.rresp : 2'b00;
  assign s1_i.rlast  = sel1 & m_o.rlast;
endmodule

// File: tb/tb_leve_axir_arb.sv
// tb_leve_axir_arb: directed self-checking bench for leve_axir_arb
module tb_leve_axir_arb;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int ntests = 0;
  int nfail = 0;
  leve_axir_arb_if #(.AW(32), .DW(32), .LW(8)) s0();
  leve_axir_arb_if #(.AW(32), .DW(32), .LW(8)) s1();
  leve_axir_arb_if #(.AW(32), .DW(32), .LW(8)) m();
  leve_axir_arb #(.AW(32), .DW(32), .LW(8)) dut (.CLK(CLK), .RST(RST), .s0_i(s0), .s1_i(s1), .m_o(m));
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [31:0] exp_addr;
    logic exp_win;
    int k;
    s0.arvalid = 0; s0.araddr = 0; s0.arlen = 0; s0.rready = 1;
    s1.arvalid = 0; s1.araddr = 0; s1.arlen = 0; s1.rready = 1;
    m.arready = 0; m.rvalid = 0; m.rdata = 0; m.rresp = 0; m.rlast = 0;
    tick; tick;
    #1;
    chk("rst_arvalid", 64'(m.arvalid), 0);
    chk("rst_araddr", 64'(m.araddr), 0);
    chk("rst_arlen", 64'(m.arlen), 0);
    chk("rst_rready", 64'(m.rready), 0);
    chk("rst_s0_rvalid", 64'(s0.rvalid), 0);
    chk("rst_s1_rvalid", 64'(s1.rvalid), 0);
    RST = 0;
    // S0 alone, single beat
    tick;
    s0.arvalid = 1; s0.araddr = 32'h1000; s0.arlen = 0;
    #1;
    chk("t1_s0_arready", 64'(s0.arready), 1);
    chk("t1_s1_arready", 64'(s1.arready), 0);
    chk("t1_m_arvalid_n", 64'(m.arvalid), 0);
    tick;
    s0.arvalid = 0;
    #1;
    chk("t1_m_arvalid", 64'(m.arvalid), 1);
    chk("t1_m_araddr", 64'(m.araddr), 64'h1000);
    chk("t1_m_arlen", 64'(m.arlen), 0);
    chk("t1_s0_arready_addr", 64'(s0.arready), 0);
    m.arready = 1;
    tick;
    m.arready = 0; m.rvalid = 1; m.rdata = 32'hDEADBEEF; m.rlast = 1; m.rresp = 0;
    #1;
    chk("t1_s0_rvalid", 64'(s0.rvalid), 1);
    chk("t1_s0_rdata", 64'(s0.rdata), 64'hDEADBEEF);
    chk("t1_s0_rlast", 64'(s0.rlast), 1);
    chk("t1_s1_rvalid", 64'(s1.rvalid), 0);
    chk("t1_m_rready", 64'(m.rready), 1);
    tick;
    m.rvalid = 0; m.rlast = 0;
    #1;
    chk("t1_idle_arvalid", 64'(m.arvalid), 0);
    chk("t1_idle_rready", 64'(m.rready), 0);
    // simultaneous requests: S1 first, S0 after a bubble; SLVERR forwarded
    s0.arvalid = 1; s0.araddr = 32'h2000;
    s1.arvalid = 1; s1.araddr = 32'h3000;
    #1;
    chk("t2_s1_arready", 64'(s1.arready), 1);
    chk("t2_s0_arready", 64'(s0.arready), 0);
    tick;
    s1.arvalid = 0;
    #1;
    chk("t2_m_araddr0", 64'(m.araddr), 64'h3000);
    chk("t2_s0_wait_addr", 64'(s0.arready), 0);
    m.arready = 1;
    tick;
    m.arready = 0; m.rvalid = 1; m.rlast = 1; m.rdata = 32'h11111111; m.rresp = 2'b10;
    #1;
    chk("t2_s1_rvalid", 64'(s1.rvalid), 1);
    chk("t2_s1_rresp", 64'(s1.rresp), 2);
    chk("t2_s0_rvalid", 64'(s0.rvalid), 0);
    chk("t2_s0_rdata", 64'(s0.rdata), 0);
    chk("t2_s0_wait_data", 64'(s0.arready), 0);
    tick;
    m.rvalid = 0; m.rlast = 0; m.rresp = 0;
    #1;
    chk("t2_bubble_arvalid", 64'(m.arvalid), 0);
    chk("t2_s0_arready", 64'(s0.arready), 1);
    tick;
    s0.arvalid = 0;
    #1;
    chk("t2_m_araddr1", 64'(m.araddr), 64'h2000);
    m.arready = 1;
    tick;
    m.arready = 0; m.rvalid = 1; m.rlast = 1; m.rdata = 32'h22222222;
    tick;
    m.rvalid = 0; m.rlast = 0;
    // S1 burst of 4 with delayed target ARREADY; S0 waits meanwhile
    s1.arvalid = 1; s1.araddr = 32'h4000; s1.arlen = 3;
    #1;
    chk("t3_s1_arready", 64'(s1.arready), 1);
    tick;
    s1.arvalid = 0;
    s0.arvalid = 1; s0.araddr = 32'h5000; s0.arlen = 3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_arvalid", 64'(m.arvalid), 1);
      chk("t3_hold_araddr", 64'(m.araddr), 64'h4000);
      chk("t3_hold_arlen", 64'(m.arlen), 3);
      chk("t3_hold_s0_arready", 64'(s0.arready), 0);
      chk("t3_hold_s1_arready", 64'(s1.arready), 0);
      tick;
    end
    m.arready = 1;
    tick;
    m.arready = 0;
    k = 0;
    for (int j = 0; j < 20 && k < 4; j++) begin
      m.rvalid = 1; m.rdata = 32'hA0 + 32'(k); m.rlast = (k == 3);
      s1.rready = j[0];
      #1;
      chk("t3_s1_rvalid", 64'(s1.rvalid), 1);
      chk("t3_s1_rdata", 64'(s1.rdata), 64'hA0 + 64'(k));
      chk("t3_m_rready", 64'(m.rready), 64'(j[0]));
      if (j[0]) k++;
      tick;
    end
    chk("t3_beats", 64'(k), 4);
    m.rvalid = 0; m.rlast = 0; s1.rready = 1;
    #1;
    chk("t3_idle_s0_arready", 64'(s0.arready), 1);
    // reset during S0 burst, then a fresh S1 request
    tick;
    s0.arvalid = 0;
    #1;
    chk("t4_m_araddr", 64'(m.araddr), 64'h5000);
    m.arready = 1;
    tick;
    m.arready = 0; m.rvalid = 1; m.rdata = 32'hB0; m.rlast = 0;
    #1;
    chk("t4_s0_rvalid", 64'(s0.rvalid), 1);
    tick;
    RST = 1; m.rvalid = 0;
    tick;
    #1;
    chk("t4_rst_arvalid", 64'(m.arvalid), 0);
    chk("t4_rst_araddr", 64'(m.araddr), 0);
    chk("t4_rst_arlen", 64'(m.arlen), 0);
    chk("t4_rst_rready", 64'(m.rready), 0);
    chk("t4_rst_s0_rvalid", 64'(s0.rvalid), 0);
    RST = 0;
    s1.arvalid = 1; s1.araddr = 32'h6000; s1.arlen = 0;
    #1;
    chk("t4_s1_arready", 64'(s1.arready), 1);
    tick;
    s1.arvalid = 0;
    #1;
    chk("t4_m_araddr_new", 64'(m.araddr), 64'h6000);
    m.arready = 1;
    tick;
    m.arready = 0; m.rvalid = 1; m.rlast = 1; m.rdata = 32'hC0;
    #1;
    chk("t4_s1_rdata", 64'(s1.rdata), 64'hC0);
    tick;
    m.rvalid = 0; m.rlast = 0;
    // continuous contention, single beats
    s0.arvalid = 1; s0.araddr = 32'h7000; s0.arlen = 0;
    s1.arvalid = 1; s1.araddr = 32'h8000; s1.arlen = 0;
    for (int t = 0; t < 4; t++) begin
`ifdef LEVE_ARB_RR_EN
      exp_win = t[0];
`else
      exp_win = 1'b1;
`endif
      exp_addr = exp_win ? 32'h8000 : 32'h7000;
      #1;
      chk("t5_s1_arready", 64'(s1.arready), 64'(exp_win));
      chk("t5_s0_arready", 64'(s0.arready), 64'(!exp_win));
      tick;
      #1;
      chk("t5_m_araddr", 64'(m.araddr), 64'(exp_addr));
      m.arready = 1;
      tick;
      m.arready = 0; m.rvalid = 1; m.rlast = 1; m.rdata = 32'hD0 + 32'(t);
      #1;
      chk("t5_win_rvalid", 64'(exp_win ? s1.rvalid : s0.rvalid), 1);
      chk("t5_lose_rvalid", 64'(exp_win ? s0.rvalid : s1.rvalid), 0);
      tick;
      m.rvalid = 0; m.rlast = 0;
    end
    s0.arvalid = 0; s1.arvalid = 0;
    tick;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
